// File: rtl/bp_be_pkg.sv
// Shared types, opcode constants and packet-width helpers for the BE issue queue.
// Issue packet layout: {fe_pkt, mem_v, fence_v, irs1_v, irs2_v}; FE packet: {exc_not_instr, ecode, pc, instr, branch_metadata_fwd}.
package bp_be_pkg;

  // RV64 major opcodes (instr[6:0]), mirrored from bp_common_rv64_pkg
  localparam logic [6:0] rv64_op_load      = 7'b0000011;
  localparam logic [6:0] rv64_op_fload     = 7'b0000111;
  localparam logic [6:0] rv64_op_misc_mem  = 7'b0001111;
  localparam logic [6:0] rv64_op_op_imm    = 7'b0010011;
  localparam logic [6:0] rv64_op_op_imm_32 = 7'b0011011;
  localparam logic [6:0] rv64_op_store     = 7'b0100011;
  localparam logic [6:0] rv64_op_fstore    = 7'b0100111;
  localparam logic [6:0] rv64_op_amo       = 7'b0101111;
  localparam logic [6:0] rv64_op_op        = 7'b0110011;
  localparam logic [6:0] rv64_op_op_32     = 7'b0111011;
  localparam logic [6:0] rv64_op_branch    = 7'b1100011;
  localparam logic [6:0] rv64_op_jalr      = 7'b1100111;
  localparam logic [6:0] rv64_op_system    = 7'b1110011;

  localparam logic [6:0] rv64_funct7_sfence_vma = 7'b0001001;
  localparam logic [2:0] rv64_funct3_priv       = 3'b000;

  typedef struct packed {
    logic mem_v;
    logic fence_v;
    logic irs1_v;
    logic irs2_v;
  } bp_be_iq_predecode_s;

  localparam int bp_be_iq_predecode_width_lp = $bits(bp_be_iq_predecode_s);

  function automatic int bp_be_iq_fe_pkt_width(input int vaddr_width, input int instr_width,
                                               input int bmf_width, input int ecode_width);
    return 1 + ecode_width + vaddr_width + instr_width + bmf_width;
  endfunction

  function automatic int bp_be_iq_iss_pkt_width(input int vaddr_width, input int instr_width,
                                                input int bmf_width, input int ecode_width);
    return bp_be_iq_fe_pkt_width(vaddr_width, instr_width, bmf_width, ecode_width)
           + bp_be_iq_predecode_width_lp;
  endfunction

endpackage

// File: rtl/bp_be_iq_predecode.sv
// Combinational predecoder: opcode/funct fields plus exception flag to {mem_v, fence_v, irs1_v, irs2_v}.
module bp_be_iq_predecode
  import bp_be_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       exc_not_instr,
  output logic [3:0] predecode
);

  bp_be_iq_predecode_s pd;

  // NOTE: every field gets a default first so no path through the case infers a latch.
  always_comb begin
    pd = '0;
    unique case (opcode)
      rv64_op_load:      begin pd.mem_v = 1'b1; pd.irs1_v = 1'b1; end
      rv64_op_store:     begin pd.mem_v = 1'b1; pd.irs1_v = 1'b1; pd.irs2_v = 1'b1; end
      rv64_op_amo:       begin pd.mem_v = 1'b1; pd.irs1_v = 1'b1; pd.irs2_v = 1'b1; end
      rv64_op_misc_mem:  pd.fence_v = 1'b1;
      rv64_op_system:    begin
        pd.irs1_v  = 1'b1;
        pd.fence_v = (funct7 == rv64_funct7_sfence_vma) && (funct3 == rv64_funct3_priv);
      end
      rv64_op_branch, rv64_op_op, rv64_op_op_32:
                         begin pd.irs1_v = 1'b1; pd.irs2_v = 1'b1; end
      rv64_op_jalr, rv64_op_op_imm, rv64_op_op_imm_32, rv64_op_fload, rv64_op_fstore:
                         pd.irs1_v = 1'b1;
      default:           pd = '0;
    endcase
    // Exception packets carry no real instruction
    if (exc_not_instr) pd = '0;
  end

  assign predecode = pd;

endmodule

// File: rtl/bp_be_issue_queue.sv
// In-order issue buffer with commit/rollback pointers and enqueue-time predecode.
// Optional same-cycle bypass of an enqueued packet to an empty issue head: define BP_BE_ISSUE_QUEUE_BYPASS_EN.
module bp_be_issue_queue
  import bp_be_pkg::*;
#(
  parameter int depth_p                     = 8,
  parameter int vaddr_width_p               = 39,
  parameter int instr_width_p               = 32,
  parameter int branch_metadata_fwd_width_p = 36,
  parameter int ecode_width_p               = 4,
  localparam int fe_pkt_width_lp  = bp_be_iq_fe_pkt_width(vaddr_width_p, instr_width_p,
                                                          branch_metadata_fwd_width_p, ecode_width_p),
  localparam int iss_pkt_width_lp = bp_be_iq_iss_pkt_width(vaddr_width_p, instr_width_p,
                                                           branch_metadata_fwd_width_p, ecode_width_p),
  localparam int cnt_width_lp     = $clog2(depth_p + 1)
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        fe_v_i,
  input  logic [fe_pkt_width_lp-1:0]  fe_pkt_i,
  output logic                        fe_ready_o,
  output logic                        iss_v_o,
  output logic [iss_pkt_width_lp-1:0] iss_pkt_o,
  input  logic                        iss_yumi_i,
  input  logic                        cmt_v_i,
  input  logic                        roll_i,
  input  logic                        clr_i,
  output logic                        empty_o,
  output logic                        full_o,
  output logic [cnt_width_lp-1:0]     count_o
);

  localparam int idx_width_lp = $clog2(depth_p);
  localparam int ptr_width_lp = idx_width_lp + 1;
  localparam int instr_lsb_lp = branch_metadata_fwd_width_p;

  logic [ptr_width_lp-1:0] wptr_r, rptr_r, cptr_r;
  logic [ptr_width_lp-1:0] wptr_n, rptr_n, cptr_n;
  logic [cnt_width_lp-1:0] count_r, count_n;
  logic                    full_r, empty_r;

  logic                        enq, yumi, cmt;
  logic [3:0]                  predecode;
  logic [iss_pkt_width_lp-1:0] enq_pkt;
  logic [iss_pkt_width_lp-1:0] mem_r [depth_p];

  bp_be_iq_predecode predecode_u (
    .opcode        (fe_pkt_i[instr_lsb_lp      +: 7]),
    .funct3        (fe_pkt_i[instr_lsb_lp + 12 +: 3]),
    .funct7        (fe_pkt_i[instr_lsb_lp + 25 +: 7]),
    .exc_not_instr (fe_pkt_i[fe_pkt_width_lp-1]),
    .predecode     (predecode)
  );

  assign enq_pkt    = {fe_pkt_i, predecode};
  // Registered full only: a commit in this same cycle cannot free a slot for this enqueue
  assign fe_ready_o = ~full_r & ~clr_i;
  assign enq        = fe_v_i & fe_ready_o;
  assign yumi       = iss_yumi_i & iss_v_o;
  assign cmt        = cmt_v_i & (cptr_r != rptr_r);

`ifdef BP_BE_ISSUE_QUEUE_BYPASS_EN
  logic bypass;
  assign bypass    = (rptr_r == wptr_r) & enq;
  assign iss_v_o   = (rptr_r != wptr_r) | bypass;
  assign iss_pkt_o = bypass ? enq_pkt : mem_r[rptr_r[idx_width_lp-1:0]];
`else
  assign iss_v_o   = (rptr_r != wptr_r);
  assign iss_pkt_o = mem_r[rptr_r[idx_width_lp-1:0]];
`endif

  always_comb begin
    wptr_n = '0;
    rptr_n = '0;
    cptr_n = '0;
    if (!clr_i) begin
      wptr_n = wptr_r + ptr_width_lp'(enq);
      cptr_n = cptr_r + ptr_width_lp'(cmt);
      // Rollback lands on the post-commit pointer and drops any same-cycle issue
      rptr_n = roll_i ? cptr_n : rptr_r + ptr_width_lp'(yumi);
    end
    count_n = cnt_width_lp'(wptr_n - cptr_n);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      cptr_r  <= '0;
      count_r <= '0;
      full_r  <= 1'b0;
      empty_r <= 1'b1;
    end else begin
      wptr_r  <= wptr_n;
      rptr_r  <= rptr_n;
      cptr_r  <= cptr_n;
      count_r <= count_n;
      full_r  <= (count_n == cnt_width_lp'(depth_p));
      empty_r <= (count_n == '0);
    end
  end

  // NOTE: payload storage has no reset; pointers alone decide which entries are meaningful.
  always_ff @(posedge clk_i) begin
    if (enq) mem_r[wptr_r[idx_width_lp-1:0]] <= enq_pkt;
  end

  assign count_o = count_r;
  assign full_o  = full_r;
  assign empty_o = empty_r;

  // Committing past the issue pointer would retire an instruction that never issued
  commit_behind_issue_a: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (cmt_v_i && !clr_i) |-> (cptr_r != rptr_r));

endmodule

// File: tb/tb_bp_be_issue_queue.sv
// Directed bench: depth 8 instance for fill/roll/clear/predecode, depth 4 instance for wrap and bypass timing.
module tb_bp_be_issue_queue;
  import bp_be_pkg::*;

  localparam int fe_w  = 112;
  localparam int iss_w = 116;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic              v8, ready8, iss_v8, yumi8, cmt8, roll8, clr8, empty8, full8;
  logic [fe_w-1:0]   pkt8;
  logic [iss_w-1:0]  iss_pkt8;
  logic [3:0]        count8;

  logic              v4, ready4, iss_v4, yumi4, cmt4, roll4, clr4, empty4, full4;
  logic [fe_w-1:0]   pkt4;
  logic [iss_w-1:0]  iss_pkt4;
  logic [2:0]        count4;

  int total = 0;
  int bad   = 0;

  bp_be_issue_queue #(.depth_p(8)) dut8 (
    .clk_i(clk), .reset_n_i(rst_n), .fe_v_i(v8), .fe_pkt_i(pkt8), .fe_ready_o(ready8),
    .iss_v_o(iss_v8), .iss_pkt_o(iss_pkt8), .iss_yumi_i(yumi8), .cmt_v_i(cmt8),
    .roll_i(roll8), .clr_i(clr8), .empty_o(empty8), .full_o(full8), .count_o(count8)
  );

  bp_be_issue_queue #(.depth_p(4)) dut4 (
    .clk_i(clk), .reset_n_i(rst_n), .fe_v_i(v4), .fe_pkt_i(pkt4), .fe_ready_o(ready4),
    .iss_v_o(iss_v4), .iss_pkt_o(iss_pkt4), .iss_yumi_i(yumi4), .cmt_v_i(cmt4),
    .roll_i(roll4), .clr_i(clr4), .empty_o(empty4), .full_o(full4), .count_o(count4)
  );

  function automatic logic [fe_w-1:0] mk_pkt(input logic exc, input logic [38:0] pc,
                                             input logic [31:0] instr);
    return {exc, (exc ? 4'h2 : 4'h0), pc, instr, 36'h123456789};
  endfunction

  function automatic logic [38:0] pc_of(input logic [iss_w-1:0] p);
    return p[72 +: 39];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    {v8, yumi8, cmt8, roll8, clr8} = '0;
    {v4, yumi4, cmt4, roll4, clr4} = '0;
    pkt8 = '0;
    pkt4 = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) tick();
    total++; if (ready8 !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", ready8); end
    total++; if (iss_v8 !== 1'b0) begin bad++; $display("FAIL reset_iss_v got=%b want=0", iss_v8); end
    total++; if (count8 !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count8); end
    total++; if (empty8 !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b want=1", empty8); end
    total++; if (full8 !== 1'b0)  begin bad++; $display("FAIL reset_full got=%b want=0", full8); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      tick();
      v8 = 1'b1;
      pkt8 = mk_pkt(1'b0, 39'h80000000 + 39'(4 * i), 32'h00000013);
      #1;
      total++; if (ready8 !== 1'b1) begin bad++; $display("FAIL fill_ready[%0d] got=%b want=1", i, ready8); end
      if (i > 0) begin
        total++; if (count8 !== 4'(i)) begin bad++; $display("FAIL fill_count[%0d] got=%0d want=%0d", i, count8, i); end
        total++; if (iss_v8 !== 1'b1) begin bad++; $display("FAIL fill_iss_v[%0d] got=%b want=1", i, iss_v8); end
      end
    end
    tick();
    pkt8 = mk_pkt(1'b0, 39'h80000020, 32'h00000013);
    #1;
    total++; if (full8 !== 1'b1)  begin bad++; $display("FAIL full_flag got=%b want=1", full8); end
    total++; if (ready8 !== 1'b0) begin bad++; $display("FAIL full_ready got=%b want=0", ready8); end
    total++; if (count8 !== 4'd8) begin bad++; $display("FAIL full_count got=%0d want=8", count8); end
    total++; if (pc_of(iss_pkt8) !== 39'h80000000) begin bad++; $display("FAIL full_head_pc got=%h want=80000000", pc_of(iss_pkt8)); end
    tick();
    v8 = 1'b0;
    #1;
    total++; if (count8 !== 4'd8) begin bad++; $display("FAIL ninth_rejected got=%0d want=8", count8); end
  endtask

  task automatic test_roll();
    for (int i = 0; i < 3; i++) begin
      tick();
      yumi8 = 1'b1;
      #1;
      total++; if (pc_of(iss_pkt8) !== 39'h80000000 + 39'(4 * i)) begin bad++; $display("FAIL issue_pc[%0d] got=%h want=%h", i, pc_of(iss_pkt8), 39'h80000000 + 39'(4 * i)); end
    end
    tick();
    yumi8 = 1'b0;
    cmt8  = 1'b1;
    #1;
    total++; if (pc_of(iss_pkt8) !== 39'h8000000C) begin bad++; $display("FAIL issue_pc_after3 got=%h want=8000000c", pc_of(iss_pkt8)); end
    tick();
    cmt8  = 1'b0;
    roll8 = 1'b1;
    yumi8 = 1'b1;
    #1;
    total++; if (count8 !== 4'd7) begin bad++; $display("FAIL commit_count got=%0d want=7", count8); end
    total++; if (ready8 !== 1'b1) begin bad++; $display("FAIL commit_ready got=%b want=1", ready8); end
    tick();
    roll8 = 1'b0;
    yumi8 = 1'b0;
    #1;
    total++; if (pc_of(iss_pkt8) !== 39'h80000004) begin bad++; $display("FAIL roll_pc got=%h want=80000004", pc_of(iss_pkt8)); end
    total++; if (count8 !== 4'd7) begin bad++; $display("FAIL roll_count got=%0d want=7", count8); end
    total++; if (iss_v8 !== 1'b1) begin bad++; $display("FAIL roll_iss_v got=%b want=1", iss_v8); end
  endtask

  task automatic test_clr();
    tick();
    v8 = 1'b1;
    pkt8 = mk_pkt(1'b0, 39'h80000040, 32'h00000013);
    {yumi8, cmt8, clr8} = 3'b111;
    #1;
    total++; if (ready8 !== 1'b0) begin bad++; $display("FAIL clr_ready got=%b want=0", ready8); end
    tick();
    {v8, yumi8, cmt8, clr8} = 4'b0000;
    #1;
    total++; if (count8 !== 4'd0) begin bad++; $display("FAIL clr_count got=%0d want=0", count8); end
    total++; if (iss_v8 !== 1'b0) begin bad++; $display("FAIL clr_iss_v got=%b want=0", iss_v8); end
    total++; if (empty8 !== 1'b1) begin bad++; $display("FAIL clr_empty got=%b want=1", empty8); end
    total++; if (ready8 !== 1'b1) begin bad++; $display("FAIL clr_ready_after got=%b want=1", ready8); end
  endtask

  task automatic pd_case(input string name, input logic exc, input logic [31:0] instr,
                         input logic [3:0] exp_pd);
    tick();
    v8 = 1'b1;
    pkt8 = mk_pkt(exc, 39'h00400000, instr);
    #1;
    tick();
    v8 = 1'b0;
    yumi8 = 1'b1;
    #1;
    total++; if (iss_v8 !== 1'b1) begin bad++; $display("FAIL pd_%s_iss_v got=%b want=1", name, iss_v8); end
    total++; if (iss_pkt8[3:0] !== exp_pd) begin bad++; $display("FAIL pd_%s_bits got=%b want=%b", name, iss_pkt8[3:0], exp_pd); end
    total++; if (iss_pkt8[115] !== exc) begin bad++; $display("FAIL pd_%s_exc got=%b want=%b", name, iss_pkt8[115], exc); end
    total++; if (iss_pkt8[71:40] !== instr) begin bad++; $display("FAIL pd_%s_instr got=%h want=%h", name, iss_pkt8[71:40], instr); end
    tick();
    yumi8 = 1'b0;
    cmt8  = 1'b1;
    #1;
    tick();
    cmt8 = 1'b0;
  endtask

  task automatic test_predecode();
    // Bits are {mem_v, fence_v, irs1_v, irs2_v}
    pd_case("lw",     1'b0, 32'h00012083, 4'b1010);
    pd_case("fence",  1'b0, 32'h0FF0000F, 4'b0100);
    pd_case("sw",     1'b0, 32'h00312223, 4'b1011);
    pd_case("sfence", 1'b0, 32'h12000073, 4'b0110);
    pd_case("exc",    1'b1, 32'h00012083, 4'b0000);
  endtask

  task automatic test_back_to_back();
    logic [38:0] exp_pc;
    logic        exp_v;
    int          issued;
    int          committed;
    exp_pc    = 39'h1000;
    issued    = 0;
    committed = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
`ifdef BP_BE_ISSUE_QUEUE_BYPASS_EN
      exp_v = 1'b1;
`else
      exp_v = (i > 0);
`endif
      v4    = 1'b1;
      pkt4  = mk_pkt(1'b0, 39'h1000 + 39'(4 * i), 32'h00000013);
      yumi4 = exp_v;
      cmt4  = (issued > committed);
      #1;
      total++; if (iss_v4 !== exp_v) begin bad++; $display("FAIL b2b_iss_v[%0d] got=%b want=%b", i, iss_v4, exp_v); end
      if (exp_v) begin
        total++; if (pc_of(iss_pkt4) !== exp_pc) begin bad++; $display("FAIL b2b_pc[%0d] got=%h want=%h", i, pc_of(iss_pkt4), exp_pc); end
      end
      total++; if (count4 !== 3'(i - committed)) begin bad++; $display("FAIL b2b_count[%0d] got=%0d want=%0d", i, count4, i - committed); end
      total++; if (count4 > 3'd2) begin bad++; $display("FAIL b2b_count_bound[%0d] got=%0d want<=2", i, count4); end
      total++; if (ready4 !== 1'b1) begin bad++; $display("FAIL b2b_ready[%0d] got=%b want=1", i, ready4); end
      if (exp_v) begin
        issued++;
        exp_pc = exp_pc + 39'd4;
      end
      if (cmt4) committed++;
    end
    tick();
    {v4, yumi4, cmt4} = 3'b000;
    #1;
  endtask

  task automatic test_async_reset();
    tick();
    total++; if (count4 === 3'd0) begin bad++; $display("FAIL areset_pre_count got=%0d want!=0", count4); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (count4 !== 3'd0) begin bad++; $display("FAIL areset_count got=%0d want=0", count4); end
    total++; if (empty4 !== 1'b1) begin bad++; $display("FAIL areset_empty got=%b want=1", empty4); end
    total++; if (iss_v4 !== 1'b0) begin bad++; $display("FAIL areset_iss_v got=%b want=0", iss_v4); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_roll();
    test_clr();
    test_predecode();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bp_be_issue_queue.md
# bp_be_issue_queue

Parametrised in-order issue buffer between the FE queue and the BE decode/dispatch stage. It replaces the single-entry issue register with a `depth_p`-entry circular buffer. Issued entries are held until commit, so a cache miss rolls issue back to the oldest uncommitted instruction without refetching. Each entry is predecoded at enqueue time: memory, fence and register-file read-enable bits.

## Interface
Parameters:
- `depth_p`, 8: entries; power of two, ≥2.
- `vaddr_width_p`, 39: PC width.
- `instr_width_p`, 32: instruction width.
- `branch_metadata_fwd_width_p`, 36: opaque FE metadata width.
- `ecode_width_p`, 4: FE exception code width.

Ports (clock is `clk_i`; reset is `reset_n_i`, asynchronous and active-low):
- `clk_i` in 1: clock.
- `reset_n_i` in 1: async active-low reset.
- `fe_v_i` in 1: FE packet valid.
- `fe_pkt_i` in `bp_be_iq_fe_pkt_s`: {exc_not_instr, ecode, pc, instr, branch_metadata_fwd}.
- `fe_ready_o` out 1: FE packet accepted when `fe_v_i & fe_ready_o`.
- `iss_v_o` out 1: head-of-issue entry valid.
- `iss_pkt_o` out `bp_be_iq_iss_pkt_s`: FE packet plus {mem_v, fence_v, irs1_v, irs2_v}.
- `iss_yumi_i` in 1: consumer takes the issue entry; legal only when `iss_v_o`.
- `cmt_v_i` in 1: oldest issued entry retires.
- `roll_i` in 1: rewind issue pointer to commit pointer.
- `clr_i` in 1: flush all entries.
- `empty_o` out 1: no uncommitted entries.
- `full_o` out 1: `depth_p` uncommitted entries.
- `count_o` out `$clog2(depth_p+1)`: uncommitted entry count.

## Operation
- Three pointers, each `$clog2(depth_p)+1` bits with a wrap bit: `wptr` (enqueue), `rptr` (issue), `cptr` (commit).
- Invariant: `cptr ≤ rptr ≤ wptr`, measured modulo with the wrap bit.
- `count = wptr - cptr`. `full = count == depth_p`. `empty = count == 0`.
- Issue valid: `iss_v_o = rptr != wptr`.
- `fe_ready_o = ~full_r & ~clr_i`.
  - Computed from registered state only; a same-cycle commit does not free a slot.
- Enqueue writes the entry at `wptr` and increments `wptr`.
- `iss_yumi_i` increments `rptr`.
- `cmt_v_i` increments `cptr`.
  - Commit with `cptr == rptr` is ignored; it fires an assertion in simulation.
- Predecode, for non-exception packets only (exception packets get all bits 0):
  - `mem_v`: LOAD, STORE, AMO.
  - `fence_v`: FENCE, FENCE.I, SFENCE.VMA.
  - `irs1_v`: JALR, LOAD, OP_IMM, OP_IMM_32, SYSTEM, BRANCH, STORE, OP, OP_32, AMO, FLOAD, FSTORE.
  - `irs2_v`: BRANCH, STORE, OP, OP_32, AMO.
- Priority: `clr_i` > `roll_i` > normal.
  - `clr_i`: `wptr = rptr = cptr = 0` next cycle. Enqueue, issue and commit that cycle are discarded.
  - `roll_i`: commit applies first; then `rptr = cptr_next`. Same-cycle `iss_yumi_i` is discarded; same-cycle enqueue proceeds.
- Wrap-around: pointers roll naturally; the wrap bit distinguishes full from empty.

## Timing
- Reset values: `fe_ready_o`=1, `iss_v_o`=0, `empty_o`=1, `full_o`=0, `count_o`=0, all pointers 0. Storage is not reset.
- Enqueue→issue latency: 1 cycle. An entry accepted in cycle t appears on `iss_pkt_o` in t+1.
- `iss_pkt_o` is a mux of registered storage, with no logic between the mux and the predecode bits.
- `full_o`, `empty_o`, `count_o` are registered and reflect updates one cycle after the event.
- Reset asserted mid-operation empties the queue immediately, asynchronously. Operation resumes on the first clock edge after deassertion.

## Configuration
- `BP_BE_ISSUE_QUEUE_BYPASS_EN` defined:
  - When `rptr == wptr` and `fe_v_i & fe_ready_o`, `iss_v_o`=1 and `iss_pkt_o` is the predecoded `fe_pkt_i` combinationally, in the same cycle.
  - The entry is still written to storage.
  - If `iss_yumi_i` is asserted that cycle, `rptr` advances together with `wptr`, keeping rollback correct.
- Undefined: no bypass; 1-cycle latency always.

## Structure
- `bp_be_pkg` holds:
  - `bp_be_iq_fe_pkt_s` and `bp_be_iq_iss_pkt_s` declare macros, with their width macros.
  - Opcode constants, reused from `bp_common_rv64_pkg`.
- Sub-module `bp_be_iq_predecode`: purely combinational instr/exception → four predecode bits. It is instantiated once on the enqueue path, and its output is stored with the entry.
- Storage is a `depth_p`-entry register array: 1 write port, 1 read port.

## Test plan
- Reset, then idle 5 cycles → `fe_ready_o`=1, `iss_v_o`=0, `count_o`=0, `empty_o`=1.
- Enqueue 8 packets (pc 0x80000000+4i) with no yumi, `depth_p`=8 → `full_o`=1 and `fe_ready_o`=0 after the 8th. A 9th `fe_v_i` is not accepted; `count_o`=8.
- Issue 3, commit 1, then `roll_i` → next cycle `iss_pkt_o.pc`=0x80000004 and `count_o`=7. A same-cycle yumi during `roll_i` does not advance `rptr`.
- `clr_i` with `fe_v_i`, `iss_yumi_i` and `cmt_v_i` all high → that cycle `fe_ready_o`=0; next cycle `count_o`=0 and `iss_v_o`=0.
- Predecode cases:
  - `lw x1,0(x2)` (0x00012083) → mem_v=1, irs1_v=1, irs2_v=0, fence_v=0.
  - `fence` (0x0FF0000F) → fence_v=1.
  - Exception packet → all predecode bits 0, `exc_not_instr`=1.
- Bypass and wrap, `depth_p`=4: 20 cycles of simultaneous enqueue, yumi and commit starting from empty.
  - With the macro: `iss_v_o` is high in the same cycle as `fe_v_i`.
  - Without the macro: `iss_v_o` is high one cycle later.
  - Both builds: PCs are in order across pointer wrap, and `count_o` never exceeds 2.
